// File: rtl/twin_tee_freq_counter.sv
// -----------------------------------------------------------------------------
// twin_tee_freq_counter
//
// Frequency counter for the squared twin-tee oscillator signal. The
// asynchronous input is passed through a three-flop synchronizer, and its
// rising edges are counted over a fixed gate window of GATE_CYCLES clocks.
// Each completed window's count is latched and read out one byte at a time.
//
// Parameters:
//   GATE_CYCLES  gate window length in clk cycles (4 .. 2^24)
//   CNT_W        edge-counter / result width (8 .. 24)
//
// Ports:
//   clk       system clock, sole clock domain
//   rst_n     asynchronous active-low reset
//   ena       block enable; low holds gate/edge counters at 0, result kept
//   osc_in    squared oscillator input, asynchronous to clk
//   hold      high on the terminal cycle freezes the latched result
//   byte_sel  selects the result byte presented on dout
//   dout      selected byte: 0/1/2 = result bytes, 3 = {ovf, wcnt}
//   valid     one-cycle pulse when a new result has been latched
//   ovf       saturation flag belonging to the latched result
// -----------------------------------------------------------------------------
module twin_tee_freq_counter #(
    parameter int GATE_CYCLES = 1000000,
    parameter int CNT_W       = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       osc_in,
    input  logic       hold,
    input  logic [1:0] byte_sel,
    output logic [7:0] dout,
    output logic       valid,
    output logic       ovf
);

    localparam int             GW     = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]  G_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_MAX = '1;

    logic             s1, s2, s3;
    logic             rise;
    logic [GW-1:0]    gcnt;
    logic [CNT_W-1:0] ecnt;
    logic             esat;
    logic [CNT_W-1:0] result;
    logic [6:0]       wcnt;

    logic             terminal;
    logic             at_max;
    logic [CNT_W-1:0] closing_cnt;
    logic             closing_ovf;
    logic [23:0]      result_ext;

    // Synchronizer: s1/s2 resolve metastability, s3 gives the previous
    // synchronized level for edge detection. Keeps running with ena low.
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= osc_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise     = s2 & ~s3;
    assign terminal = ena && (gcnt == G_LAST);
    assign at_max   = (ecnt == C_MAX);

    // A rise on the terminal cycle belongs to the window that is closing,
    // so the latched value folds it in (saturating) rather than dropping it.
    assign closing_cnt = at_max ? ecnt : ecnt + {{(CNT_W-1){1'b0}}, rise};
    assign closing_ovf = esat | (at_max & rise);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcnt   <= '0;
            ecnt   <= '0;
            esat   <= 1'b0;
            result <= '0;
            ovf    <= 1'b0;
            wcnt   <= '0;
            valid  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!ena) begin
                // Disabled: counting restarts cleanly at gcnt=0 on re-enable,
                // while the last latched result stays readable.
                gcnt <= '0;
                ecnt <= '0;
                esat <= 1'b0;
            end else if (terminal) begin
                if (!hold) begin
                    result <= closing_cnt;
                    ovf    <= closing_ovf;
                    wcnt   <= wcnt + 7'd1;
                    valid  <= 1'b1;
                end
                // The window closes regardless of hold; the next one is
                // back-to-back with no dead cycle.
                gcnt <= '0;
                ecnt <= '0;
                esat <= 1'b0;
            end else begin
                gcnt <= gcnt + 1'b1;
                if (rise) begin
                    if (at_max) begin
                        esat <= 1'b1;
                    end else begin
                        ecnt <= ecnt + 1'b1;
                    end
                end
            end
        end
    end

    // Readout: result zero-extended to 24 bits so bytes above CNT_W read 0.
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        result_ext              = '0;
        result_ext[CNT_W-1:0]   = result;
        dout                    = 8'h00;
        case (byte_sel)
            2'd0:    dout = result_ext[7:0];
            2'd1:    dout = result_ext[15:8];
            2'd2:    dout = result_ext[23:16];
            default: dout = {ovf, wcnt};
        endcase
    end

endmodule

// File: tb/tb_twin_tee_freq_counter.sv
// -----------------------------------------------------------------------------
// tb_twin_tee_freq_counter
//
// Two instances share all stimulus: a 24-bit counter and an 8-bit counter,
// both with a 1000-cycle gate. A reference model counts rises of the sampled
// input as plain integers per window and pushes the expected readout into a
// scoreboard queue at each unheld terminal edge; a monitor pops on the cycle
// the result must be visible and checks valid, ovf and all four dout bytes
// on every cycle.
// -----------------------------------------------------------------------------
module tb_twin_tee_freq_counter;

    localparam int GATE = 1000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       osc_in;
    logic       hold;
    logic [1:0] byte_sel;
    logic [7:0] dout24, dout8;
    logic       valid24, valid8;
    logic       ovf24, ovf8;

    always #5 clk = ~clk;

    twin_tee_freq_counter #(.GATE_CYCLES(GATE), .CNT_W(24)) u_dut24 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc_in), .hold(hold),
        .byte_sel(byte_sel), .dout(dout24), .valid(valid24), .ovf(ovf24)
    );

    twin_tee_freq_counter #(.GATE_CYCLES(GATE), .CNT_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc_in), .hold(hold),
        .byte_sel(byte_sel), .dout(dout8), .valid(valid8), .ovf(ovf8)
    );

    typedef struct {
        int unsigned cyc;   // cycle count at the edge that latches the result
        logic [23:0] r24;
        logic        o24;
        logic [7:0]  r8;
        logic        o8;
        logic [6:0]  w;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, req);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [23:0] r, input logic o,
                                            input logic [6:0] w, input int sel);
        case (sel)
            0:       return r[7:0];
            1:       return r[15:8];
            2:       return r[23:16];
            default: return {o, w};
        endcase
    endfunction

    // ---------------- reference model ----------------
    // Works from the rules directly: an input rise seen at edge k is counted
    // at edge k+2; a window is GATE enabled edges; the reported value is the
    // true count clipped to the result width, with ovf meaning "clipped".
    int unsigned m_gpos  = 0;   // position within the window of the next cycle
    int unsigned m_count = 0;   // unbounded rise count of the open window
    int unsigned m_wcnt  = 0;
    bit          hist[$];       // osc_in samples, newest at the back

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                m_gpos  = 0;
                m_count = 0;
                m_wcnt  = 0;
                hist    = '{0, 0, 0, 0};
                q.delete();
            end else begin
                int unsigned n;
                bit          rise_now;
                hist.push_back(osc_in);
                if (hist.size() > 4) void'(hist.pop_front());
                // hist[3] = this edge, hist[1] = two edges ago, hist[0] = three.
                rise_now = hist[1] && !hist[0];
                if (!ena) begin
                    m_gpos  = 0;
                    m_count = 0;
                end else begin
                    n = m_count + (rise_now ? 1 : 0);
                    if (m_gpos == GATE - 1) begin
                        if (!hold) begin
                            exp_t e;
                            m_wcnt = (m_wcnt + 1) % 128;
                            e.cyc  = cyc;
                            e.r24  = (n > 24'hFFFFFF) ? 24'hFFFFFF : 24'(n);
                            e.o24  = (n > 24'hFFFFFF);
                            e.r8   = (n > 255) ? 8'hFF : 8'(n);
                            e.o8   = (n > 255);
                            e.w    = 7'(m_wcnt);
                            q.push_back(e);
                        end
                        m_count = 0;
                        m_gpos  = 0;
                    end else begin
                        m_count = n;
                        m_gpos++;
                    end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    logic exp_v;

    initial begin
        cur      = '{default: 0};
        byte_sel = 2'd0;
        forever begin
            @(negedge clk);
            exp_v = 1'b0;
            if (!rst_n) begin
                q.delete();
                cur = '{default: 0};
            end else begin
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    check("valid_missed_cycle", cyc, q[0].cyc);
                    void'(q.pop_front());
                end
                if (q.size() > 0 && q[0].cyc == cyc) begin
                    exp_v = 1'b1;
                    cur   = q.pop_front();
                end
            end
            check("valid24", valid24, exp_v);
            check("valid8",  valid8,  exp_v);
            check("ovf24",   ovf24,   cur.o24);
            check("ovf8",    ovf8,    cur.o8);
            for (int s = 0; s < 4; s++) begin
                byte_sel = 2'(s);
                #1;
                check($sformatf("dout24_sel%0d", s), dout24, exp_byte(cur.r24, cur.o24, cur.w, s));
                check($sformatf("dout8_sel%0d", s),  dout8,  exp_byte({16'h0, cur.r8}, cur.o8, cur.w, s));
            end
        end
    end

    // ---------------- stimulus ----------------
    int ph = 0;

    // period < 0: osc low; period 0: random level each cycle; else square wave.
    task automatic run(input int n, input int period);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            if (period < 0)       osc_in = 1'b0;
            else if (period == 0) osc_in = 1'($urandom % 2);
            else                  osc_in = ((ph % period) < (period / 2));
            ph++;
        end
    endtask

    task automatic wait_gpos(input int target, input int period);
        for (int i = 0; i < 2 * GATE && m_gpos != target; i++) run(1, period);
        check("gate_position_reached", m_gpos, target);
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b0;
        hold   = 1'b0;
        osc_in = 1'b0;

        // Reset with the input toggling: monitor expects all-zero outputs.
        run(20, 2);
        rst_n = 1'b1;
        ena   = 1'b1;

        // Basic count: period 10 -> 100 per full window.
        run(3 * GATE, 10);

        // Overflow: period 2 -> 500 rises (8-bit saturates), then back to 100.
        run(2 * GATE, 2);
        run(2 * GATE, 10);

        // Hold across exactly one terminal edge while the rate halves.
        hold = 1'b1;
        run(GATE, 20);
        hold = 1'b0;
        run(2 * GATE, 20);

        // Boundary: a single rise counted on the terminal cycle.
        run(GATE, -1);
        wait_gpos(GATE - 3, -1);
        osc_in = 1'b1;
        run(2 * GATE, -1);

        // Enable dropped mid-window for 20 cycles.
        run(GATE, 10);
        wait_gpos(500, 10);
        ena = 1'b0;
        run(20, 10);
        ena = 1'b1;
        run(3 * GATE, 10);

        // Randomized windows: random rates, hold toggling, short ena drops.
        for (int w = 0; w < 6; w++) begin
            int p;
            p = ($urandom % 3 == 0) ? 0 : int'($urandom_range(2, 40));
            for (int c = 0; c < 10; c++) begin
                hold = ($urandom % 4 == 0);
                if ($urandom % 8 == 0) begin
                    ena = 1'b0;
                    run(int'($urandom_range(1, 30)), p);
                    ena = 1'b1;
                end
                run(GATE / 10, p);
            end
        end
        hold = 1'b0;
        run(2 * GATE, 10);

        // Asynchronous reset mid-window: outputs clear without a clock edge.
        wait_gpos(300, 10);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid24", valid24, 1'b0);
        check("async_rst_valid8",  valid8,  1'b0);
        check("async_rst_ovf24",   ovf24,   1'b0);
        check("async_rst_ovf8",    ovf8,    1'b0);
        check("async_rst_dout24",  dout24,  8'h00);
        check("async_rst_dout8",   dout8,   8'h00);
        run(5, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/twin_tee_freq_counter.md
# twin_tee_freq_counter

Digital frequency counter directly downstream of the twin-tee op-amp oscillator. The oscillator's analog output is squared by the pad-side comparator and enters this block as a single-bit digital input. The block synchronizes it and counts its rising edges over a fixed gate window of `clk` cycles. Each completed window's count is latched and presented one byte at a time on `uo_out`, so the oscillator frequency can be read with a plain logic analyser or microcontroller.

## Interface
Parameters:
- `GATE_CYCLES`, default 1000000: gate window length in `clk` cycles; legal range 4 to 2^24.
- `CNT_W`, default 24: edge-counter and result width; legal range 8 to 24.

Ports:
- `clk`  input  1  system clock; sole clock domain.
- `rst_n`  input  1  asynchronous, active-low reset.
- `ena`  input  1  block enable.
  - Low: gate and edge counters are held at 0 synchronously.
  - The latched result is retained.
- `osc_in`  input  1  squared oscillator signal, asynchronous to `clk`; driven from `ui_in[0]`.
- `hold`  input  1  when high, freezes the latched result; counting continues.
- `byte_sel`  input  2  selects which byte of the result appears on `dout`.
- `dout`  output  8  selected result byte.
- `valid`  output  1  one-cycle pulse when a new result is latched.
- `ovf`  output  1  saturation flag belonging to the currently latched result.

## Operation
- **Synchronizer:** `s1 <= osc_in`, `s2 <= s1`, `s3 <= s2`; `rise = s2 & ~s3`. No other logic touches `osc_in`.
- **Gate counter:** `gcnt` runs 0 .. `GATE_CYCLES-1` while `ena`=1, then wraps to 0. The terminal cycle is `gcnt == GATE_CYCLES-1`.
- **Edge counter:** `ecnt` (`CNT_W` bits) increments on each cycle with `rise`=1.
  - It saturates at 2^`CNT_W`-1.
  - A rise while already saturated sets internal `esat`.
- **Terminal cycle, `hold`=0:**
  - The result latch is loaded with `ecnt` plus this cycle's `rise` (saturating).
  - `ovf` is loaded with `esat`, or with the saturation caused by this cycle's rise.
  - `wcnt` (7-bit completed-window counter) increments, wrapping 127→0.
  - `valid` is 1 on the following cycle only.
- **Terminal cycle, `hold`=1:** the latch, `ovf` and `wcnt` are unchanged and no `valid` pulse is produced.
- **Every terminal cycle, regardless of `hold`:** `ecnt` and `esat` clear to 0. A rise on the terminal cycle belongs to the closing window.
- **`ena` falling:**
  - `gcnt`, `ecnt` and `esat` are cleared on the next edge.
  - The synchronizer keeps running.
  - The first window after `ena` rises starts at `gcnt`=0.
- **`dout` mapping:**
  - 0 → result[7:0]
  - 1 → result[15:8]
  - 2 → result[23:16]
  - 3 → {`ovf`, `wcnt`[6:0]}
  - Bits at or above `CNT_W` read 0.
  - `dout` is purely combinational from registered state and `byte_sel`.

## Timing
- **Reset:**
  - All outputs are 0: `dout`=0x00 for every `byte_sel`, `valid`=0, `ovf`=0.
  - All counters and synchronizer flops are 0.
  - Reset asserted mid-window discards the partial count.
  - The first window after deassertion begins on the first `clk` edge with `rst_n`=1 and `ena`=1.
- **Input latency:** `osc_in` rising before edge k makes `rise`=1 in the cycle after edge k+1, so it is counted at edge k+2.
- **Input rate:** `osc_in` must stay high ≥1 and low ≥1 full `clk` cycle per period, so the maximum countable frequency is `clk`/2. Faster input undercounts and is not flagged.
- **Result latency:**
  - The result latches at the edge ending the terminal cycle.
  - `valid` is high in the next cycle.
  - `dout` reflects the new value in the same cycle `valid` is high.
- **Steady state:**
  - Windows are back-to-back with no dead cycles.
  - Period is exactly `GATE_CYCLES` clocks.
  - Result = round-down count of rises in that window.
- **`hold`:** sampled only on the terminal cycle. Toggling it elsewhere has no effect.
- **`byte_sel`:** may change any cycle; `dout` follows combinationally.

## Test plan
- **Reset values:** `rst_n`=0 with `osc_in` toggling → `dout`=0 for all four `byte_sel`, `valid`=0, `ovf`=0.
- **Basic count:** `GATE_CYCLES`=1000, `osc_in` period 10 clk →
  - from the second window on, each `valid` pulse shows result 100 (byte0=0x64, byte1=0x00);
  - `valid` pulses are exactly 1000 cycles apart;
  - `byte_sel`=3 shows `wcnt` incrementing by 1 per pulse.
- **Overflow:** `CNT_W`=8, `GATE_CYCLES`=1000, `osc_in` period 2 clk (500 rises) → result 255, `ovf`=1, byte1=0x00. Next window at period 10 → result 100, `ovf`=0.
- **Hold:** `hold`=1 across a terminal cycle with the count changed from 100 to 50 (period 20) →
  - no `valid` pulse, result stays 100, `wcnt` unchanged;
  - after `hold`=0, the next window reports 50.
- **Boundary edge:** align a single rise so it is counted on the terminal cycle → it appears in the closing result, and the following window starts from 0.
- **Enable / reset mid-window:** drop `ena` at cycle 500 of a window for 20 cycles →
  - the result from before the drop is retained;
  - the next `valid` comes 1000 cycles after `ena` returns.
  
  Then assert `rst_n`=0 mid-window → all outputs go to 0 immediately, asynchronously.
